// File: rtl/io_int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : io_int_ctrl_if
// Description : Bundle of the input-port pins, CPU interrupt handshake and
//               status flags of the I/O interrupt controller.
//               master = pin/CPU side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_int_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d0_e;
  logic [WIDTH-1:0] d1_e;
  logic [WIDTH-1:0] d2_e;
  logic [WIDTH-1:0] d3_e;
  logic [3:0]       int_en;
  logic             int_ack;
  logic             eoi;
  logic             int_req;
  logic [1:0]       int_vec;
  logic [WIDTH-1:0] int_data;
  logic [3:0]       pend;
  logic [3:0]       overrun;

  modport master (
    output d0_e, d1_e, d2_e, d3_e, int_en, int_ack, eoi,
    input  int_req, int_vec, int_data, pend, overrun
  );

  modport slave (
    input  d0_e, d1_e, d2_e, d3_e, int_en, int_ack, eoi,
    output int_req, int_vec, int_data, pend, overrun
  );
endinterface
`default_nettype wire

// File: rtl/io_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_int_ctrl
// Description : Interrupt controller for four asynchronous WIDTH-bit input
//               ports. Each port is synchronised, value changes are detected
//               and snapshotted, and a single CPU interrupt line is shared
//               between the ports with round-robin arbitration. One port is
//               serviced per request / ack / end-of-interrupt handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module io_int_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  io_int_ctrl_if.slave  bus
);

  localparam int         c_NPORT      = 4;
  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_REQ     = 2'd1;
  localparam logic [1:0] c_ST_SERV    = 2'd2;
  // The synchroniser is cleared by reset and needs two clocks to reflect the
  // pins again; prev needs one more clock to hold that value. Change
  // detection is therefore enabled only once the counter saturates, so a
  // level held through reset release is never seen as a change.
  localparam logic [1:0] c_PRIME_DONE = 2'd3;

  // Per-port pipeline: pins -> s1 -> s2 -> prev, plus the latched snapshot
  logic [WIDTH-1:0]   w_din  [c_NPORT];
  logic [WIDTH-1:0]   r_s1   [c_NPORT];
  logic [WIDTH-1:0]   r_s2   [c_NPORT];
  logic [WIDTH-1:0]   r_prev [c_NPORT];
  logic [WIDTH-1:0]   r_snap [c_NPORT];

  logic [1:0]         r_prime_cnt;
  logic               w_primed;

  logic [c_NPORT-1:0] w_chg;
  logic [c_NPORT-1:0] w_set;
  logic [c_NPORT-1:0] w_elig;
  logic [c_NPORT-1:0] r_pend;
  logic [c_NPORT-1:0] r_overrun;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [1:0]         r_rr_ptr;
  logic [1:0]         w_grant;
  logic [1:0]         w_scan_idx;
  logic               w_any;
  logic               w_load;
  logic               w_take_ack;
  logic               w_take_eoi;

  logic               r_int_req;
  logic [1:0]         r_int_vec;
  logic [WIDTH-1:0]   r_int_data;

  assign w_din[0] = bus.d0_e;
  assign w_din[1] = bus.d1_e;
  assign w_din[2] = bus.d2_e;
  assign w_din[3] = bus.d3_e;

  // Priming counter: saturates once the synchroniser and prev are valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prime_cnt <= 2'd0;
    end else if (r_prime_cnt != c_PRIME_DONE) begin
      r_prime_cnt <= r_prime_cnt + 2'd1;
    end
  end

  assign w_primed = (r_prime_cnt == c_PRIME_DONE);

  generate
    for (genvar gi = 0; gi < c_NPORT; gi++) begin : g_chg
      assign w_chg[gi] = w_primed && (r_s2[gi] != r_prev[gi]);
    end
  endgenerate

  // A masked port neither records new changes nor competes for the line
  assign w_set  = w_chg & bus.int_en;
  assign w_elig = r_pend & bus.int_en;
  assign w_any  = |w_elig;

  // Round-robin pick: scan offsets high to low so the smallest offset from
  // rr_ptr that is eligible is the one left standing
  always_comb begin
    w_grant    = r_rr_ptr;
    w_scan_idx = r_rr_ptr;
    for (int k = c_NPORT - 1; k >= 0; k--) begin
      w_scan_idx = r_rr_ptr + 2'(k);
      if (w_elig[w_scan_idx]) begin
        w_grant = w_scan_idx;
      end
    end
  end

  // Synchroniser, previous-value and snapshot registers for every port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_NPORT; i++) begin
        r_s1[i]   <= '0;
        r_s2[i]   <= '0;
        r_prev[i] <= '0;
        r_snap[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_NPORT; i++) begin
        r_s1[i]   <= w_din[i];
        r_s2[i]   <= r_s1[i];
        r_prev[i] <= r_s2[i];
        if (w_set[i]) begin
          r_snap[i] <= r_s2[i];
        end
      end
    end
  end

  // Pending and sticky overrun flags; a new change beats a same-cycle ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend    <= '0;
      r_overrun <= '0;
    end else begin
      for (int i = 0; i < c_NPORT; i++) begin
        if (w_set[i]) begin
          r_pend[i] <= 1'b1;
        end else if (w_take_ack && (r_int_vec == 2'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
      r_overrun <= r_overrun | (w_set & r_pend);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; ack is only looked at in REQ, eoi only in SERV
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_any)       w_state_nxt = c_ST_REQ;
      c_ST_REQ:  if (bus.int_ack) w_state_nxt = c_ST_SERV;
      c_ST_SERV: if (bus.eoi)     w_state_nxt = c_ST_IDLE;
      default:                    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM output decode: grant load, ack acceptance and end-of-interrupt
  always_comb begin
    w_load     = 1'b0;
    w_take_ack = 1'b0;
    w_take_eoi = 1'b0;
    case (r_state)
      c_ST_IDLE: w_load     = w_any;
      c_ST_REQ:  w_take_ack = bus.int_ack;
      c_ST_SERV: w_take_eoi = bus.eoi;
      default: ;
    endcase
  end

  // Registered CPU-facing outputs; vector and data are frozen until the
  // next grant so the core can read them throughout service
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_req  <= 1'b0;
      r_int_vec  <= 2'd0;
      r_int_data <= '0;
    end else if (w_load) begin
      r_int_req  <= 1'b1;
      r_int_vec  <= w_grant;
      r_int_data <= r_snap[w_grant];
    end else if (w_take_ack) begin
      r_int_req  <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the port that was serviced
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 2'd0;
    end else if (w_take_eoi) begin
      r_rr_ptr <= r_int_vec + 2'd1;
    end
  end

  assign bus.int_req  = r_int_req;
  assign bus.int_vec  = r_int_vec;
  assign bus.int_data = r_int_data;
  assign bus.pend     = r_pend;
  assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire
